cnn_batch_ctrl: RTL and testbench
=================================

Name: cnn_batch_ctrl

Overview:
Synthesisable batch sequencer that runs the cnn core over a batch of stored images without bench intervention.
- Per image: copies the image from a source BRAM into the core's IF1 BRAM, pulses start, waits for done with a timeout, and compares the result against the image's stored label.
- Accumulates pass/fail/timeout statistics for the batch.
- Sits between the source-image BRAM, the IF1 BRAM write port and the cnn start/done/result interface.

Parameters:
- IMG_WORDS, 256: 32-bit words per image.
- N_IMG, 16: maximum images per batch.
- RES_W, 8: result/label width.
- CNT_W, 16: width of statistic counters.
- TIMEOUT, 2000000: cycles allowed in WAIT before the image is declared timed out.
- ADDR_STEP, 4: address increment per word (byte addressing).

Ports:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-low.
- run in 1: start batch (single-cycle pulse).
- n_img in $clog2(N_IMG+1): images to run; clamped to N_IMG.
- busy out 1: batch in progress.
- batch_done out 1: level, high from batch end until next accepted run.
- SRC_ADDR out 32, SRC_EN out 1, SRC_DOUT in 32: source BRAM read port, 1-cycle read latency.
- IF1_ADDR out 32, IF1_EN out 1, IF1_WE out 4, IF1_DIN out 32: IF1 BRAM write port.
- core_start out 1: single-cycle start pulse to the cnn core.
- core_done in 1: level done from the core.
- core_result in RES_W: inference result, valid while core_done is high.
- pass_cnt, fail_cnt, timeout_cnt out CNT_W each: batch statistics.
- last_result out RES_W: most recent result.
- first_fail out $clog2(N_IMG): index of the first failing image.
- first_fail_vld out 1: first_fail is valid.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; every output 0, including SRC_EN, IF1_EN, IF1_WE, core_start, all counters and flags. Reset asserted mid-batch aborts it immediately; nothing is resumed after reset.
- Source layout: image i occupies record words i*(IMG_WORDS+1) .. i*(IMG_WORDS+1)+IMG_WORDS. The last word of each record is the label, held in bits [RES_W-1:0]. Address = word index * ADDR_STEP.
- IDLE / DONE: run accepted only here. On accept, all counters, first_fail_vld and batch_done clear and busy rises next cycle. run while busy is ignored. Clamped n_img == 0 goes straight to DONE, so batch_done is high 2 cycles after run.
- LOAD (IMG_WORDS+2 cycles):
  - Cycle k, k = 0..IMG_WORDS: SRC_EN=1, read record word k.
  - Cycles k = 1..IMG_WORDS: write IF1 word k-1 with SRC_DOUT; IF1_EN=1, IF1_WE=4'hF, IF1_ADDR=(k-1)*ADDR_STEP.
  - Final drain cycle latches the label.
  - IF1_WE=0 on all non-write cycles.
- START (1 cycle): core_start=1.
- WAIT: core_done is sampled from the cycle after START; any done level present during START is ignored.
  - First sampled core_done=1: latch core_result into last_result, go to CHECK.
  - If TIMEOUT cycles elapse first: timeout_cnt++ and fail_cnt++; go to NEXT.
  - done and timeout on the same cycle: done wins.
- CHECK (1 cycle): result == label increments pass_cnt; otherwise fail_cnt++. The first failure (fail or timeout) sets first_fail = image index and first_fail_vld=1; both hold for the rest of the batch.
- NEXT: index++. If index == clamped n_img, go to DONE (busy=0, batch_done=1); otherwise go to LOAD.
- Counters saturate at 2^CNT_W-1.
- Invariant: pass_cnt + fail_cnt == images completed; timeout_cnt <= fail_cnt.

Optional Feature:
CNN_BATCH_STOP_ON_FAIL_EN
- Defined: the first failure or timeout goes directly to DONE after the counters update; the remaining images are not run.
- Undefined: the batch always runs all clamped n_img images.

Test Plan (IMG_WORDS=4, N_IMG=4, TIMEOUT=50, RES_W=8):
- Reset/idle: hold rst low then release, no run -> all outputs 0, SRC_EN/IF1_EN low indefinitely.
- Single pass: n_img=1, record = {1,2,3,4,label 39}, core model asserts done 10 cycles after start with result 39 -> IF1 words 0..3 = 1,2,3,4 written on consecutive cycles; core_start pulsed exactly once; pass_cnt=1, fail_cnt=0, last_result=39, batch_done=1.
- Mixed batch: n_img=4, labels 39,7,7,1, core returns 39,7,9,1 -> pass_cnt=3, fail_cnt=1, first_fail=2, first_fail_vld=1.
- Timeout: core never asserts done, n_img=2 -> timeout_cnt=2, fail_cnt=2, WAIT lasts exactly 50 cycles per image, first_fail=0.
- Boundaries:
  - n_img=0 -> batch_done 2 cycles after run, counters 0.
  - n_img=9 -> clamped, exactly 4 core_start pulses.
  - run pulsed while busy -> ignored.
  - core_done already high during START -> not sampled; result latched only from the next cycle.
- Reset mid-batch: rst low during the WAIT of image 1 -> all outputs 0 at once; a new run restarts from image 0. With CNN_BATCH_STOP_ON_FAIL_EN, the mixed batch stops after image 2 with pass_cnt=2, fail_cnt=1.

Source files
------------

// File: rtl/cnn_batch_ctrl.sv
// Batch sequencer: copies each stored image into the cnn IF1 BRAM, runs the core, checks against the label.
// Optional define CNN_BATCH_STOP_ON_FAIL_EN ends the batch at the first failure or timeout.
module cnn_batch_ctrl #(
    parameter int IMG_WORDS = 256,
    parameter int N_IMG     = 16,
    parameter int RES_W     = 8,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 2000000,
    parameter int ADDR_STEP = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic [$clog2(N_IMG+1)-1:0] n_img,
    output logic                       busy,
    output logic                       batch_done,
    output logic [31:0]                SRC_ADDR,
    output logic                       SRC_EN,
    input  logic [31:0]                SRC_DOUT,
    output logic [31:0]                IF1_ADDR,
    output logic                       IF1_EN,
    output logic [3:0]                 IF1_WE,
    output logic [31:0]                IF1_DIN,
    output logic                       core_start,
    input  logic                       core_done,
    input  logic [RES_W-1:0]           core_result,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [CNT_W-1:0]           fail_cnt,
    output logic [CNT_W-1:0]           timeout_cnt,
    output logic [RES_W-1:0]           last_result,
    output logic [$clog2(N_IMG)-1:0]   first_fail,
    output logic                       first_fail_vld
);
    localparam int NW = $clog2(N_IMG + 1);
    localparam int FW = $clog2(N_IMG);
    localparam int LW = $clog2(IMG_WORDS + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
`ifdef CNN_BATCH_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_LOAD, S_START, S_WAIT, S_CHECK, S_NEXT, S_DONE
    } state_t;

    state_t           state;
    logic [NW-1:0]    n_lim;
    logic [NW-1:0]    img_idx;
    logic [LW-1:0]    ld_cnt;
    logic [TW-1:0]    wait_cnt;
    logic [31:0]      src_ptr;
    logic [RES_W-1:0] label;
    logic             batch_end;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Records are contiguous, so src_ptr simply keeps counting across images.
    assign batch_end = (state == S_INIT) ? (n_lim == '0) : (img_idx + NW'(1) == n_lim);

    // NOTE: data passes straight from the source read port; gating on IF1_EN keeps it 0 in reset and idle.
    assign IF1_DIN = IF1_EN ? SRC_DOUT : '0;

    // NOTE: every register here is reset asynchronously and updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            batch_done     <= 1'b0;
            SRC_ADDR       <= '0;
            SRC_EN         <= 1'b0;
            IF1_ADDR       <= '0;
            IF1_EN         <= 1'b0;
            IF1_WE         <= '0;
            core_start     <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            timeout_cnt    <= '0;
            last_result    <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            n_lim          <= '0;
            img_idx        <= '0;
            ld_cnt         <= '0;
            wait_cnt       <= '0;
            src_ptr        <= '0;
            label          <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (run) begin
                        state          <= S_INIT;
                        busy           <= 1'b1;
                        batch_done     <= 1'b0;
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        timeout_cnt    <= '0;
                        first_fail     <= '0;
                        first_fail_vld <= 1'b0;
                        img_idx        <= '0;
                        src_ptr        <= '0;
                        n_lim          <= (n_img > NW'(N_IMG)) ? NW'(N_IMG) : n_img;
                    end
                end
                S_INIT, S_NEXT: begin
                    if (state == S_NEXT) img_idx <= img_idx + NW'(1);
                    if (batch_end) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        batch_done <= 1'b1;
                    end else begin
                        state    <= S_LOAD;
                        ld_cnt   <= '0;
                        SRC_EN   <= 1'b1;
                        SRC_ADDR <= src_ptr;
                        src_ptr  <= src_ptr + 32'(ADDR_STEP);
                    end
                end
                S_LOAD: begin
                    ld_cnt <= ld_cnt + LW'(1);
                    // Read of word k+1 and write of IF1 word k are both set up at the end of cycle k.
                    if (ld_cnt < LW'(IMG_WORDS)) begin
                        SRC_EN   <= 1'b1;
                        SRC_ADDR <= src_ptr;
                        src_ptr  <= src_ptr + 32'(ADDR_STEP);
                        IF1_EN   <= 1'b1;
                        IF1_WE   <= 4'hF;
                        IF1_ADDR <= 32'(ld_cnt) * 32'(ADDR_STEP);
                    end else begin
                        SRC_EN <= 1'b0;
                        IF1_EN <= 1'b0;
                        IF1_WE <= '0;
                    end
                    if (ld_cnt == LW'(IMG_WORDS + 1)) begin
                        label      <= SRC_DOUT[RES_W-1:0];
                        core_start <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (core_done) begin
                        last_result <= core_result;
                        state       <= S_CHECK;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        timeout_cnt <= sat_inc(timeout_cnt);
                        fail_cnt    <= sat_inc(fail_cnt);
                        if (!first_fail_vld) begin
                            first_fail     <= img_idx[FW-1:0];
                            first_fail_vld <= 1'b1;
                        end
                        if (STOP_ON_FAIL) begin
                            state      <= S_DONE;
                            busy       <= 1'b0;
                            batch_done <= 1'b1;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_CHECK: begin
                    if (last_result == label) begin
                        pass_cnt <= sat_inc(pass_cnt);
                        state    <= S_NEXT;
                    end else begin
                        fail_cnt <= sat_inc(fail_cnt);
                        if (!first_fail_vld) begin
                            first_fail     <= img_idx[FW-1:0];
                            first_fail_vld <= 1'b1;
                        end
                        if (STOP_ON_FAIL) begin
                            state      <= S_DONE;
                            busy       <= 1'b0;
                            batch_done <= 1'b1;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_batch_ctrl.sv
// Directed bench for cnn_batch_ctrl with a source BRAM model, an IF1 capture memory and a simple core model.
`timescale 1ns/1ps
module tb_cnn_batch_ctrl;
    localparam int IMG_WORDS = 4;
    localparam int N_IMG     = 4;
    localparam int RES_W     = 8;
    localparam int CNT_W     = 16;
    localparam int TIMEOUT   = 50;
    localparam int ADDR_STEP = 4;
`ifdef CNN_BATCH_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;
    logic [2:0] n_img = '0;
    logic busy, batch_done, SRC_EN, IF1_EN, core_start, first_fail_vld;
    logic [31:0] SRC_ADDR, IF1_ADDR, IF1_DIN;
    logic [31:0] src_dout = '0;
    logic [3:0] IF1_WE;
    logic core_done;
    logic [RES_W-1:0] core_result, last_result;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, timeout_cnt;
    logic [1:0] first_fail;
    logic [163:0] all_outs;

    int checks = 0;
    int failures = 0;

    cnn_batch_ctrl #(
        .IMG_WORDS(IMG_WORDS), .N_IMG(N_IMG), .RES_W(RES_W), .CNT_W(CNT_W),
        .TIMEOUT(TIMEOUT), .ADDR_STEP(ADDR_STEP)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .n_img(n_img),
        .busy(busy), .batch_done(batch_done),
        .SRC_ADDR(SRC_ADDR), .SRC_EN(SRC_EN), .SRC_DOUT(src_dout),
        .IF1_ADDR(IF1_ADDR), .IF1_EN(IF1_EN), .IF1_WE(IF1_WE), .IF1_DIN(IF1_DIN),
        .core_start(core_start), .core_done(core_done), .core_result(core_result),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt),
        .last_result(last_result), .first_fail(first_fail), .first_fail_vld(first_fail_vld)
    );

    assign all_outs = {busy, batch_done, SRC_ADDR, SRC_EN, IF1_ADDR, IF1_EN, IF1_WE, IF1_DIN,
                       core_start, pass_cnt, fail_cnt, timeout_cnt, last_result, first_fail, first_fail_vld};

    always #5 clk = ~clk;

    // Source BRAM: four 5-word records, label in the last word (upper bits deliberately non-zero on image 1).
    logic [31:0] src_mem [0:31];
    logic [31:0] if1_mem [0:3];
    initial begin
        for (int i = 0; i < 32; i++) src_mem[i] = 32'hDEAD_0000 + 32'(i);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) src_mem[i*5+j] = 32'(10*i + j + 1);
            if1_mem[i] = '0;
        end
        src_mem[4]  = 32'd39;
        src_mem[9]  = 32'hABCD_0007;
        src_mem[14] = 32'd7;
        src_mem[19] = 32'd1;
    end
    always @(posedge clk) if (SRC_EN) src_dout <= src_mem[SRC_ADDR[6:2]];
    always @(posedge clk) if (IF1_EN && IF1_WE == 4'hF) if1_mem[IF1_ADDR[3:2]] <= IF1_DIN;

    // Bus activity log, sampled mid-cycle.
    int cyc = 0;
    int wr_n = 0, src_n = 0, we_bad = 0;
    int wr_cyc [0:255];
    logic [31:0] wr_addr [0:255];
    logic [31:0] wr_data [0:255];
    logic [31:0] src_log [0:255];
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (IF1_EN) begin
            if (IF1_WE != 4'hF) we_bad++;
            if (wr_n < 256) begin
                wr_cyc[wr_n]  = cyc;
                wr_addr[wr_n] = IF1_ADDR;
                wr_data[wr_n] = IF1_DIN;
            end
            wr_n++;
        end else if (IF1_WE != 4'h0) begin
            we_bad++;
        end
        if (SRC_EN) begin
            if (src_n < 256) src_log[src_n] = SRC_ADDR;
            src_n++;
        end
    end

    // Core model: done drops when a start is seen, rises core_delay cycles later with res_tab[image].
    logic [RES_W-1:0] res_tab [0:3];
    int start_cnt = 0, start_base = 0, core_delay = 10, core_left = 0;
    bit core_hang = 1'b0, pre_done = 1'b0, core_busy = 1'b0;
    logic [1:0] core_img = '0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_done   <= 1'b0;
            core_result <= '0;
            core_busy   <= 1'b0;
            core_left   <= 0;
        end else if (core_start) begin
            start_cnt <= start_cnt + 1;
            core_img  <= 2'(start_cnt - start_base);
            core_done <= 1'b0;
            core_busy <= !core_hang;
            core_left <= core_delay;
        end else if (pre_done) begin
            core_done   <= 1'b1;
            core_result <= 8'd99;
        end else if (core_busy) begin
            if (core_left <= 1) begin
                core_done   <= 1'b1;
                core_result <= res_tab[core_img];
                core_busy   <= 1'b0;
            end else begin
                core_left <= core_left - 1;
            end
        end
    end

    task automatic do_run(input logic [2:0] n);
        @(negedge clk);
        run = 1'b1;
        n_img = n;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!batch_done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (batch_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: batch_done=%b after %0d cycles, required 1", name, batch_done, k);
        end
    endtask

    task automatic test_reset();
        int idle_bad = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs !== '0) begin
            failures++;
            $display("FAIL reset_outs: got %h required 0", all_outs);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (SRC_EN !== 1'b0 || IF1_EN !== 1'b0 || busy !== 1'b0 || core_start !== 1'b0) idle_bad++;
        end
        checks++;
        if (idle_bad != 0 || all_outs !== '0) begin
            failures++;
            $display("FAIL idle_quiet: %0d active cycles, outs %h, required 0", idle_bad, all_outs);
        end
    endtask

    task automatic test_single_pass();
        int s0, w0, r0, bad;
        res_tab[0] = 8'd39;
        core_delay = 10;
        start_base = start_cnt;
        s0 = start_cnt; w0 = wr_n; r0 = src_n;
        do_run(3'd1);
        wait_done("single");
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL single_starts: got %0d required 1", start_cnt - s0);
        end
        checks++;
        if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || timeout_cnt !== 16'd0) begin
            failures++;
            $display("FAIL single_counts: got pass=%0d fail=%0d tmo=%0d required 1/0/0", pass_cnt, fail_cnt, timeout_cnt);
        end
        checks++;
        if (last_result !== 8'd39 || busy !== 1'b0 || first_fail_vld !== 1'b0) begin
            failures++;
            $display("FAIL single_result: got last=%0d busy=%b ffv=%b required 39/0/0", last_result, busy, first_fail_vld);
        end
        bad = 0;
        for (int j = 0; j < 4; j++)
            if (wr_addr[w0+j] !== 32'(4*j) || wr_data[w0+j] !== 32'(j+1) || wr_cyc[w0+j] != wr_cyc[w0] + j) bad++;
        checks++;
        if (wr_n - w0 != 4 || bad != 0) begin
            failures++;
            $display("FAIL single_if1_writes: got %0d writes %0d bad, required 4 consecutive writes 1..4", wr_n - w0, bad);
        end
        bad = 0;
        for (int j = 0; j < 5; j++) if (src_log[r0+j] !== 32'(4*j)) bad++;
        checks++;
        if (src_n - r0 != 5 || bad != 0) begin
            failures++;
            $display("FAIL single_src_reads: got %0d reads %0d bad, required 5 at 0..16", src_n - r0, bad);
        end
    endtask

    task automatic test_mixed_batch();
        int s0 = start_cnt;
        res_tab[0] = 8'd39; res_tab[1] = 8'd7; res_tab[2] = 8'd9; res_tab[3] = 8'd1;
        start_base = start_cnt;
        do_run(3'd4);
        wait_done("mixed");
        checks++;
        if (pass_cnt !== (STOP ? 16'd2 : 16'd3) || fail_cnt !== 16'd1 || timeout_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mixed_counts: got pass=%0d fail=%0d tmo=%0d required %0d/1/0", pass_cnt, fail_cnt, timeout_cnt, STOP ? 2 : 3);
        end
        checks++;
        if (first_fail !== 2'd2 || first_fail_vld !== 1'b1) begin
            failures++;
            $display("FAIL mixed_first_fail: got %0d vld=%b required 2 vld=1", first_fail, first_fail_vld);
        end
        checks++;
        if (start_cnt - s0 != (STOP ? 3 : 4) || last_result !== (STOP ? 8'd9 : 8'd1)) begin
            failures++;
            $display("FAIL mixed_progress: got starts=%0d last=%0d required %0d/%0d", start_cnt - s0, last_result, STOP ? 3 : 4, STOP ? 9 : 1);
        end
        checks++;
        if (if1_mem[0] !== (STOP ? 32'd21 : 32'd31) || if1_mem[3] !== (STOP ? 32'd24 : 32'd34)) begin
            failures++;
            $display("FAIL mixed_if1_data: got %0d,%0d required %0d,%0d", if1_mem[0], if1_mem[3], STOP ? 21 : 31, STOP ? 24 : 34);
        end
    endtask

    task automatic test_clamp_and_busy_run();
        int s0 = start_cnt;
        res_tab[0] = 8'd39; res_tab[1] = 8'd7; res_tab[2] = 8'd7; res_tab[3] = 8'd1;
        start_base = start_cnt;
        do_run(3'd7);
        repeat (15) @(negedge clk);
        do_run(3'd1);
        wait_done("clamp");
        checks++;
        if (start_cnt - s0 != 4 || pass_cnt !== 16'd4 || fail_cnt !== 16'd0 || first_fail_vld !== 1'b0) begin
            failures++;
            $display("FAIL clamp_busy_run: got starts=%0d pass=%0d fail=%0d ffv=%b required 4/4/0/0",
                     start_cnt - s0, pass_cnt, fail_cnt, first_fail_vld);
        end
    endtask

    task automatic test_zero_images();
        @(negedge clk);
        run = 1'b1;
        n_img = 3'd0;
        @(negedge clk);
        run = 1'b0;
        checks++;
        if (busy !== 1'b1 || batch_done !== 1'b0) begin
            failures++;
            $display("FAIL zero_cycle1: got busy=%b done=%b required 1/0", busy, batch_done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || batch_done !== 1'b1 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || first_fail_vld !== 1'b0) begin
            failures++;
            $display("FAIL zero_cycle2: got busy=%b done=%b pass=%0d fail=%0d ffv=%b required 0/1/0/0/0",
                     busy, batch_done, pass_cnt, fail_cnt, first_fail_vld);
        end
    endtask

    task automatic test_timeout();
        int s0 = start_cnt;
        int n_exp = STOP ? 1 : 2;
        int gap_exp = STOP ? 51 : 52;
        core_hang = 1'b1;
        start_base = start_cnt;
        do_run(3'd2);
        for (int i = 0; i < n_exp; i++) begin
            int k = 0;
            while (core_start !== 1'b1 && k < 200) begin
                @(negedge clk);
                k++;
            end
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!(SRC_EN === 1'b1 || batch_done === 1'b1) && k < 200);
            checks++;
            if (k != gap_exp) begin
                failures++;
                $display("FAIL timeout_wait_len img%0d: got %0d cycles start-to-next required %0d", i, k, gap_exp);
            end
        end
        wait_done("timeout");
        checks++;
        if (timeout_cnt !== 16'(n_exp) || fail_cnt !== 16'(n_exp) || pass_cnt !== 16'd0 || start_cnt - s0 != n_exp) begin
            failures++;
            $display("FAIL timeout_counts: got tmo=%0d fail=%0d pass=%0d starts=%0d required %0d/%0d/0/%0d",
                     timeout_cnt, fail_cnt, pass_cnt, start_cnt - s0, n_exp, n_exp, n_exp);
        end
        checks++;
        if (first_fail !== 2'd0 || first_fail_vld !== 1'b1) begin
            failures++;
            $display("FAIL timeout_first_fail: got %0d vld=%b required 0 vld=1", first_fail, first_fail_vld);
        end
        core_hang = 1'b0;
    endtask

    task automatic test_done_during_start();
        res_tab[0] = 8'd39;
        start_base = start_cnt;
        @(negedge clk);
        pre_done = 1'b1;
        @(negedge clk);
        pre_done = 1'b0;
        do_run(3'd1);
        wait_done("early_done");
        checks++;
        if (last_result !== 8'd39 || pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin
            failures++;
            $display("FAIL early_done_ignored: got last=%0d pass=%0d fail=%0d required 39/1/0", last_result, pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_reset_mid_batch();
        int s0 = start_cnt;
        int k = 0;
        int r0;
        res_tab[0] = 8'd39; res_tab[1] = 8'd7; res_tab[2] = 8'd9; res_tab[3] = 8'd1;
        start_base = start_cnt;
        do_run(3'd4);
        while (start_cnt - s0 < 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            failures++;
            $display("FAIL midreset_outs: got %h required 0", all_outs);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_base = start_cnt;
        r0 = src_n;
        do_run(3'd1);
        wait_done("restart");
        checks++;
        if (src_log[r0] !== 32'd0 || pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || last_result !== 8'd39) begin
            failures++;
            $display("FAIL restart_image0: got addr=%0d pass=%0d fail=%0d last=%0d required 0/1/0/39",
                     src_log[r0], pass_cnt, fail_cnt, last_result);
        end
    endtask

    task automatic test_write_enables();
        checks++;
        if (we_bad != 0) begin
            failures++;
            $display("FAIL if1_we_pattern: got %0d bad cycles required 0", we_bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_mixed_batch();
        test_clamp_and_busy_run();
        test_zero_images();
        test_timeout();
        test_done_during_start();
        test_reset_mid_batch();
        test_write_enables();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
